// File: rtl/fifo_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sched_pkg
// Purpose  : Shared pointer type, full/empty helper and parameter sanity check
//            for the shared-FIFO write scheduler.
// Revision : 1.0
// ============================================================================
package fifo_sched_pkg;

    localparam int PTR_MAX       = 16;
    localparam int PTR_WIDTH_DEF = 3;

    typedef logic [PTR_WIDTH_DEF:0] ptr_t;

    typedef struct packed {
        logic full;
        logic empty;
    } flags_t;

    // Pointers arrive zero-extended to PTR_MAX+1 bits; pw selects the wrap bit.
    function automatic flags_t calc_flags(input logic [PTR_MAX:0] wptr,
                                          input logic [PTR_MAX:0] rptr,
                                          input int               pw);
        flags_t           f;
        logic [PTR_MAX:0] diff;
        diff    = wptr ^ rptr;
        f.full  = 1'b1;
        f.empty = 1'b1;
        for (int b = 0; b <= PTR_MAX; b++) begin
            if (b < pw) begin
                if (diff[b]) begin
                    f.full  = 1'b0;
                    f.empty = 1'b0;
                end
            end else if (b == pw) begin
                if (diff[b]) f.empty = 1'b0;
                else         f.full  = 1'b0;
            end
        end
        return f;
    endfunction

    function automatic bit depth_ok(input int depth, input int pw);
        return (pw >= 1) && (pw < PTR_MAX) && (depth == (1 << pw));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin arbiter with internal priority pointer; priority
//            moves past the winner whenever the grant strobe is asserted.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       en_i,
    input  logic                       strobe_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] prio_q;
    logic [IW-1:0] prio_d;
    logic          hit;
    int            j;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        hit       = 1'b0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(prio_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (en_i && !hit && req_i[j]) begin
                hit       = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = IW'(j);
            end
        end
    end

    assign prio_d = (gnt_idx_o == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;

    always_ff @(posedge clk) begin
        if (rst)           prio_q <= '0;
        else if (strobe_i) prio_q <= prio_d;
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_sched
// Purpose  : Arbitrates NUM_REQ writers into one FIFO memory and drives its
//            pointers, enables and status. FIFO_WR_SCHED_ERR_EN adds a sticky
//            err_underflow output.
// Revision : 1.0
// ============================================================================
module fifo_wr_sched
    import fifo_sched_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          rd_req,
    output logic                          rd_valid,
    output logic                          mem_w_en,
    output logic                          mem_r_en,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic [PTR_WIDTH:0]            mem_wptr,
    output logic [PTR_WIDTH:0]            mem_rptr,
    output logic                          full,
    output logic                          empty,
    output logic [PTR_WIDTH:0]            count,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
`ifdef FIFO_WR_SCHED_ERR_EN
    ,
    output logic                          err_underflow
`endif
);

    localparam int IW = $clog2(NUM_REQ);

    if (!depth_ok(DEPTH, PTR_WIDTH)) begin : g_bad_depth
        $error("fifo_wr_sched: DEPTH must equal 2**PTR_WIDTH");
    end
    if (NUM_REQ < 2) begin : g_bad_nreq
        $error("fifo_wr_sched: NUM_REQ must be at least 2");
    end

    logic [PTR_WIDTH:0] wptr_q, wptr_d;
    logic [PTR_WIDTH:0] rptr_q, rptr_d;
    logic [IW-1:0]      grant_id_q, grant_id_d;
    logic               rd_valid_q;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    flags_t             flags;

    // Flags come only from registered pointers, so req_ready never sees rd_req.
    assign flags = calc_flags({{(PTR_MAX - PTR_WIDTH){1'b0}}, wptr_q},
                              {{(PTR_MAX - PTR_WIDTH){1'b0}}, rptr_q},
                              PTR_WIDTH);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_valid),
        .en_i      (!flags.full),
        .strobe_i  (mem_w_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign req_ready = gnt;
    assign mem_w_en  = |gnt;
    assign mem_wdata = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign mem_r_en  = rd_req & !flags.empty;

    always_comb begin
        wptr_d     = wptr_q + {{PTR_WIDTH{1'b0}}, mem_w_en};
        rptr_d     = rptr_q + {{PTR_WIDTH{1'b0}}, mem_r_en};
        grant_id_d = mem_w_en ? gnt_idx : grant_id_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            grant_id_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            grant_id_q <= grant_id_d;
            rd_valid_q <= mem_r_en;
        end
    end

    assign mem_wptr = wptr_q;
    assign mem_rptr = rptr_q;
    assign full     = flags.full;
    assign empty    = flags.empty;
    assign count    = wptr_q - rptr_q;
    assign grant_id = grant_id_q;
    assign rd_valid = rd_valid_q;

`ifdef FIFO_WR_SCHED_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_q | (rd_req & flags.empty);
    end

    assign err_underflow = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_sched
// Purpose  : Scoreboard bench for fifo_wr_sched with a registered-read memory.
// Revision : 1.0
// ============================================================================
module tb_fifo_wr_sched;
    import fifo_sched_pkg::*;

    localparam int DW = 8;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            rd_req;
    logic            rd_valid;
    logic            mem_w_en;
    logic            mem_r_en;
    logic [DW-1:0]   mem_wdata;
    logic [3:0]      mem_wptr;
    logic [3:0]      mem_rptr;
    logic            full;
    logic            empty;
    logic [3:0]      count;
    logic [1:0]      grant_id;
`ifdef FIFO_WR_SCHED_ERR_EN
    logic            err_underflow;
`endif

    always #5 clk = ~clk;

    fifo_wr_sched #(
        .DEPTH      (8),
        .DATA_WIDTH (DW),
        .PTR_WIDTH  (3),
        .NUM_REQ    (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rd_req    (rd_req),
        .rd_valid  (rd_valid),
        .mem_w_en  (mem_w_en),
        .mem_r_en  (mem_r_en),
        .mem_wdata (mem_wdata),
        .mem_wptr  (mem_wptr),
        .mem_rptr  (mem_rptr),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .grant_id  (grant_id)
`ifdef FIFO_WR_SCHED_ERR_EN
        ,
        .err_underflow (err_underflow)
`endif
    );

    // External FIFO memory with registered read data
    logic [DW-1:0] mem [8];
    logic [DW-1:0] mem_dout;
    always @(posedge clk) begin
        if (mem_w_en) mem[mem_wptr[2:0]] <= mem_wdata;
        if (mem_r_en) mem_dout <= mem[mem_rptr[2:0]];
    end

    int            n_chk = 0;
    int            n_bad = 0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] d [NR];
    ptr_t          m_wptr, m_rptr;
    int            m_count, m_prio, m_gid;
    logic          m_rdv, m_err;
    logic [DW-1:0] m_inflight;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wptr     = '0;
        m_rptr     = '0;
        m_count    = 0;
        m_prio     = 0;
        m_gid      = 0;
        m_rdv      = 1'b0;
        m_err      = 1'b0;
        m_inflight = '0;
        sb.delete();
    endtask

    task automatic tick(input logic [NR-1:0] v, input logic rd, input logic r);
        int            g;
        int            j;
        logic          pop;
        logic          mfull, mempty;
        logic [NR-1:0] er;
        logic [DW-1:0] nxt;
        req_valid = v;
        rd_req    = rd;
        rst       = r;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = d[i];
        @(negedge clk);
        mfull  = (m_count == 8);
        mempty = (m_count == 0);
        g = -1;
        if (!mfull) begin
            for (int k = 0; k < NR; k++) begin
                j = (m_prio + k) % NR;
                if (g < 0 && v[j]) g = j;
            end
        end
        er  = (g >= 0) ? NR'(1 << g) : '0;
        pop = rd & !mempty;
        chk_eq("req_ready", 32'(req_ready), 32'(er));
        chk_eq("mem_w_en",  32'(mem_w_en),  32'(g >= 0));
        chk_eq("mem_r_en",  32'(mem_r_en),  32'(pop));
        chk_eq("full",      32'(full),      32'(mfull));
        chk_eq("empty",     32'(empty),     32'(mempty));
        chk_eq("count",     32'(count),     32'(m_count));
        chk_eq("wptr",      32'(mem_wptr),  32'(m_wptr));
        chk_eq("rptr",      32'(mem_rptr),  32'(m_rptr));
        chk_eq("grant_id",  32'(grant_id),  32'(m_gid));
        chk_eq("rd_valid",  32'(rd_valid),  32'(m_rdv));
        if (m_rdv)  chk_eq("rd_data", 32'(mem_dout), 32'(m_inflight));
        if (g >= 0) chk_eq("wdata",   32'(mem_wdata), 32'(d[g]));
`ifdef FIFO_WR_SCHED_ERR_EN
        chk_eq("err_underflow", 32'(err_underflow), 32'(m_err));
`endif
        if (g >= 0) sb.push_back(d[g]);
        nxt = m_inflight;
        if (pop && sb.size() > 0) nxt = sb.pop_front();
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            if (rd && mempty) m_err = 1'b1;
            if (g >= 0) begin
                m_wptr = m_wptr + 1'b1;
                m_count++;
                m_gid  = g;
                m_prio = (g + 1) % NR;
                d[g]   = d[g] + 8'd1;
            end
            if (pop) begin
                m_rptr = m_rptr + 1'b1;
                m_count--;
            end
            m_rdv      = pop;
            m_inflight = nxt;
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rd_req    = 1'b0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) d[i] = 8'(i * 64);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // underflow attempts on an empty FIFO
        repeat (3) tick(4'h0, 1'b1, 1'b0);
        tick(4'h0, 1'b0, 1'b0);

        // fill with all writers, observe full, then drain in writer order
        repeat (9) tick(4'hF, 1'b0, 1'b0);
        repeat (8) tick(4'h0, 1'b1, 1'b0);
        tick(4'h0, 1'b0, 1'b0);

        // full: push from requester 2 with a pop, then requester 2 wins
        repeat (8) tick(4'hF, 1'b0, 1'b0);
        tick(4'b0100, 1'b1, 1'b0);
        tick(4'b0100, 1'b0, 1'b0);
        repeat (8) tick(4'h0, 1'b1, 1'b0);
        tick(4'h0, 1'b0, 1'b0);

        // empty: push 0xA5 with a pop, no bypass
        d[0] = 8'hA5;
        tick(4'b0001, 1'b1, 1'b0);
        tick(4'h0, 1'b1, 1'b0);
        tick(4'h0, 1'b0, 1'b0);

        // steady push/pop at count 4, pointers wrap
        repeat (4) tick(4'hF, 1'b0, 1'b0);
        repeat (20) tick(4'($urandom_range(1, 15)), 1'b1, 1'b0);

        // reset with count 5 and a pop in flight
        tick(4'b0001, 1'b0, 1'b0);
        tick(4'h0, 1'b1, 1'b0);
        tick(4'h0, 1'b0, 1'b1);
        tick(4'hF, 1'b0, 1'b0);
        tick(4'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
